ram_stream_reader: RTL

//  Burst read engine for the multi-port register-file RAM. Accepts a (base, len) command,

---
 rtl/ram_stream_reader_pkg.sv | 15 +
 rtl/ram_stream_reader_if.sv | 26 ++
 rtl/ram_stream_reader_word.sv | 20 ++
 rtl/ram_stream_reader.sv | 119 +++++++++++
 4 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared types for the RAM burst stream reader: FSM state encoding and width helper.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Word count must represent 0..2**aw inclusive, hence one extra bit.
  function automatic int unsigned len_width(int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Command, RAM read port and output stream of the burst reader bundled as one interface.
interface ram_stream_reader_if #(
  parameter int Width        = 8,
  parameter int AddressWidth = 4
);
  logic                    start;
  logic [AddressWidth-1:0] base;
  logic [AddressWidth:0]   len;
  logic [AddressWidth-1:0] raddr;
  logic [Width-1:0]        rdata;
  logic                    out_valid;
  logic                    out_ready;
  logic [Width-1:0]        out_data;
  logic                    busy;
  logic                    done;

  modport slave (
    input  start, base, len, rdata, out_ready,
    output raddr, out_valid, out_data, busy, done
  );

  modport master (
    output start, base, len, rdata, out_ready,
    input  raddr, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/ram_stream_reader_word.sv
// Word register with synchronous reset value RST, preset to all ones, and write enable.
module ram_stream_reader_word #(
  parameter int              Width = 8,
  parameter logic [Width-1:0] RST  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             pst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)      q <= RST;
    else if (pst) q <= '1;
    else if (we)  q <= d;
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst read engine: streams len words from base (wrapping) out of an async-read RAM.
// RAM_STREAM_READER_CSUM_EN adds an XOR checksum port csum over the transferred words.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int Width        = 8,
  parameter int AddressWidth = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef RAM_STREAM_READER_CSUM_EN
  output logic [Width-1:0] csum,
`endif
  ram_stream_reader_if.slave bus
);

  localparam int LenW = int'(len_width(AddressWidth));

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] raddr_q, raddr_d;
  logic [LenW-1:0]         rem_q, rem_d;
  logic                    vld_q, vld_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    load;
  logic                    xfer;
  logic [Width-1:0]        data_w;

  assign xfer = vld_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    rem_d   = rem_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          raddr_d = bus.base;
          rem_d   = bus.len;
          if (bus.len != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        // Load whenever the output slot is empty or being drained this cycle.
        if (!vld_q || bus.out_ready) begin
          load    = 1'b1;
          vld_d   = 1'b1;
          raddr_d = raddr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == LenW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer) begin
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      raddr_q <= '0;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ram_stream_reader_word #(.Width(Width), .RST('0)) u_data (
    .clk (clk),
    .rst (rst),
    .we  (load),
    .pst (1'b0),
    .d   (bus.rdata),
    .q   (data_w)
  );

`ifdef RAM_STREAM_READER_CSUM_EN
  logic [Width-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst)                            csum_q <= '0;
    else if (state_q == IDLE && bus.start) csum_q <= '0;
    else if (xfer)                      csum_q <= csum_q ^ data_w;
  end

  assign csum = csum_q;
`endif

  assign bus.raddr     = raddr_q;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_w;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
